riscv_mem_arbiter: RTL
======================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 64, memory address width in bits.
- LINE_W, 128, cache line width in bits.
- TIMEOUT_CYC, 1024, maximum cycles a granted transaction may wait for mem_ready.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ic_mem_rden  in  1  icache line-fill request.
- ic_addr  in  ADDR_W  icache line address.
- dc_mem_rden  in  1  dcache line-fill request.
- dc_mem_wren  in  1  dcache write-back request.
- dc_addr  in  ADDR_W  dcache line address.
- dc_wdata  in  LINE_W  dcache write-back line.
- mem_ready  in  1  DRAM transaction done (one-cycle pulse).
- mem_rdata  in  LINE_W  DRAM read line.
- mem_rden  out  1  DRAM read enable.
- mem_wren  out  1  DRAM write enable.
- mem_addr  out  ADDR_W  DRAM address.
- mem_wdata  out  LINE_W  DRAM write line.
- ic_mem_ready  out  1  icache transaction done.
- dc_mem_ready  out  1  dcache transaction done.
- rdata  out  LINE_W  mem_rdata broadcast to both caches, combinational.
- mem_err  out  1  one-cycle pulse on transaction timeout.

Function
REQ-003 The FSM SHALL have states IDLE, GRANT_IC, GRANT_DC.
REQ-004 A 1-bit last_grant register SHALL record the last granted requester: IC=0, DC=1.
REQ-005 In IDLE, if only one requester asserts, that requester SHALL be granted on the next edge.
REQ-006 In IDLE with both requesting, the requester not equal to last_grant SHALL be granted (round-robin).
REQ-007 Requests SHALL be level-sensitive, sampled only in IDLE.
REQ-008 On the grant edge, the arbiter SHALL latch the following into output registers:
- mem_addr;
- mem_wdata (dc_wdata for DC, else unchanged);
- the operation: write if dc_mem_wren, else read; dc_mem_wren has priority when dc_mem_rden is also high.
REQ-009 In GRANT_x, mem_rden/mem_wren SHALL be driven from the latched operation continuously until mem_ready.
REQ-010 ic_mem_ready SHALL equal mem_ready AND state==GRANT_IC; dc_mem_ready SHALL equal mem_ready AND state==GRANT_DC.
REQ-011 mem_ready in IDLE SHALL be ignored.
REQ-012 On mem_ready in GRANT_IC, the FSM SHALL go to IDLE and set last_grant=0.
REQ-013 On mem_ready in GRANT_DC for a write with dc_mem_rden high that cycle, the FSM SHALL stay in GRANT_DC (write-back→allocate lock).
- It SHALL relatch dc_addr and switch to read, with no IDLE bubble and no icache interleave.
REQ-014 Any other mem_ready in GRANT_DC SHALL return the FSM to IDLE and set last_grant=1.
REQ-015 Requester deassertion while granted SHALL NOT abort the transaction; it completes on mem_ready.
REQ-016 A 0-based wait counter SHALL be active in GRANT_x:
- it clears on grant and on lock relatch;
- it increments each cycle without mem_ready.
REQ-017 When the counter reaches TIMEOUT_CYC-1 without mem_ready:
- mem_err SHALL pulse for one cycle;
- the FSM SHALL go to IDLE;
- last_grant SHALL update as on completion;
- no *_mem_ready is asserted.
REQ-018 Minimum turnaround SHALL be one IDLE cycle between unlocked transactions; grant latency from request in IDLE SHALL be 1 cycle.

Reset
REQ-019 On rst, outputs SHALL be:
- mem_rden=0, mem_wren=0;
- mem_addr=0, mem_wdata=0;
- mem_err=0;
- state=IDLE, last_grant=0, counter=0.
REQ-020 rst mid-transaction SHALL abandon the transaction immediately; no *_mem_ready SHALL be asserted afterward.

Verification
REQ-021 Single IC: ic_mem_rden=1, ic_addr=0x1000 in IDLE, mem_ready pulse 3 cycles later -> the following response:
- mem_rden=1, mem_addr=0x1000 the cycle after the request;
- ic_mem_ready=1 with mem_ready;
- IDLE next.
REQ-022 Tie after reset: both request, IC addr 0x100, DC read addr 0x200 -> the following response:
- DC granted first (mem_addr=0x200);
- after completion and one IDLE cycle, IC granted (0x100).
REQ-023 Write-back lock: DC wren with addr 0x300, wdata 0xA5..A5, IC also requesting; on mem_ready, dc_mem_rden=1, addr 0x400 -> the following response:
- mem_wren to mem_rden switch with mem_addr=0x400 and no IDLE cycle;
- IC granted only after the read completes.
REQ-024 Timeout: grant IC, hold mem_ready=0 for TIMEOUT_CYC cycles -> the following response:
- mem_err pulses once at cycle TIMEOUT_CYC after grant;
- ic_mem_ready stays 0;
- state returns to IDLE.
REQ-025 Reset mid-op: assert rst 2 cycles into GRANT_DC -> the following response:
- mem_rden=0 and mem_wren=0 asynchronously;
- a later mem_ready pulse produces no dc_mem_ready.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one DRAM port between the icache and dcache line-fill paths.
// Holds a dcache write-back -> allocate pair on the port and aborts stalled transactions.
module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned LINE_W      = 128,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_mem_rden,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              dc_mem_rden,
  input  logic              dc_mem_wren,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              ic_mem_ready,
  output logic              dc_mem_ready,
  output logic [LINE_W-1:0] rdata,
  output logic              mem_err
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StGrantIc, StGrantDc} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic dc_req;
  logic grant_dc;
  logic timeout;

  assign dc_req   = dc_mem_rden | dc_mem_wren;
  // Tie goes to the requester that was not served last (IC=0, DC=1).
  assign grant_dc = dc_req & (~ic_mem_rden | ~last_grant_q);
  assign timeout  = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (grant_dc) begin
          state_d = StGrantDc;
          addr_d  = dc_addr;
          wdata_d = dc_wdata;
          write_d = dc_mem_wren;
        end else if (ic_mem_rden) begin
          state_d = StGrantIc;
          addr_d  = ic_addr;
          write_d = 1'b0;
        end
      end
      StGrantIc: begin
        if (mem_ready || timeout) begin
          state_d      = StIdle;
          last_grant_d = 1'b0;
          err_d        = ~mem_ready;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGrantDc: begin
        if (mem_ready && write_q && dc_mem_rden) begin
          // Write-back done with a fill pending: keep the port and turn it into the read.
          addr_d  = dc_addr;
          write_d = 1'b0;
          cnt_d   = '0;
        end else if (mem_ready || timeout) begin
          state_d      = StIdle;
          last_grant_d = 1'b1;
          err_d        = ~mem_ready;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign mem_rden     = (state_q != StIdle) & ~write_q;
  assign mem_wren     = (state_q != StIdle) & write_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign ic_mem_ready = mem_ready & (state_q == StGrantIc);
  assign dc_mem_ready = mem_ready & (state_q == StGrantDc);
  assign rdata        = mem_rdata;
  assign mem_err      = err_q;

endmodule
